// File: rtl/tx_dpdm.sv
// Bus-side USB transmitter: drives SYNC, the NRZI body from tx_nrzi, then EOP (SE0, SE0, J).
// The body length is latched from the request type when the packet is accepted.
module tx_dpdm #(
    parameter int unsigned DATA_BITS   = 88,
    parameter int unsigned HSHAKE_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_data,
    input  logic       send_hshake,
    input  logic       abort,
    input  logic       s_in,
    output logic       start_tx_nrzi,
    output logic       bit_req,
    output logic       end_tx_nrzi,
    output logic [1:0] bus_out,
    output logic       enable,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [1:0] LineJ   = 2'b10;
    localparam logic [1:0] LineK   = 2'b01;
    localparam logic [1:0] LineSe0 = 2'b00;

    localparam logic [6:0] DataLen   = 7'(DATA_BITS);
    localparam logic [6:0] HshakeLen = 7'(HSHAKE_BITS);

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StSend,
        StEop1,
        StEop2,
        StEop3
    } state_e;

    state_e     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [6:0] total_q, total_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 7'd0;
            total_q <= 7'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        total_d       = total_q;
        start_tx_nrzi = 1'b0;
        bit_req       = 1'b0;
        end_tx_nrzi   = 1'b0;
        tx_done       = 1'b0;
        enable        = 1'b0;
        bus_out       = LineJ;

        unique case (state_q)
            StIdle: begin
                if (send_hshake || send_data) begin
                    // Handshake wins when both requests are present.
                    total_d       = send_hshake ? HshakeLen : DataLen;
                    start_tx_nrzi = 1'b1;
                    cnt_d         = 7'd0;
                    state_d       = StSync;
                end
            end
            StSync: begin
                enable  = 1'b1;
                // KJKJKJKK: odd indices are J except the final K at index 7.
                bus_out = (cnt_q[0] && cnt_q != 7'd7) ? LineJ : LineK;
                cnt_d   = cnt_q + 7'd1;
                if (cnt_q == 7'd7) begin
                    cnt_d   = 7'd0;
                    state_d = StSend;
                end
            end
            StSend: begin
                enable  = 1'b1;
                bus_out = s_in ? LineJ : LineK;
                bit_req = 1'b1;
                cnt_d   = cnt_q + 7'd1;
                if (cnt_q == total_q - 7'd1) begin
                    end_tx_nrzi = 1'b1;
                    cnt_d       = 7'd0;
                    state_d     = StEop1;
                end
            end
            StEop1: begin
                enable  = 1'b1;
                bus_out = LineSe0;
                state_d = StEop2;
            end
            StEop2: begin
                enable  = 1'b1;
                bus_out = LineSe0;
                state_d = StEop3;
            end
            StEop3: begin
                enable  = 1'b1;
                bus_out = LineJ;
                tx_done = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 7'd0;
            end
        endcase

        // An aborted packet must not signal completion to either side.
        if (abort) begin
            state_d       = StIdle;
            cnt_d         = 7'd0;
            start_tx_nrzi = 1'b0;
            end_tx_nrzi   = 1'b0;
            tx_done       = 1'b0;
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_tx_dpdm.sv
// Self-checking bench for tx_dpdm: directed packets from the test plan, then random traffic,
// each cycle compared against a packet-offset reference model.
module tb_tx_dpdm;

    localparam int DataBits = 88;
    localparam int HsBits   = 8;
    localparam logic [1:0] LineJ = 2'b10;
    localparam logic [1:0] LineK = 2'b01;
    localparam logic [1:0] LineX = 2'b00;

    logic       clk = 1'b0;
    logic       rst, send_data, send_hshake, abort, s_in;
    logic       start_tx_nrzi, bit_req, end_tx_nrzi, enable, busy, tx_done;
    logic [1:0] bus_out;

    always #5 clk = ~clk;

    tx_dpdm #(
        .DATA_BITS  (DataBits),
        .HSHAKE_BITS(HsBits)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .send_data    (send_data),
        .send_hshake  (send_hshake),
        .abort        (abort),
        .s_in         (s_in),
        .start_tx_nrzi(start_tx_nrzi),
        .bit_req      (bit_req),
        .end_tx_nrzi  (end_tx_nrzi),
        .bus_out      (bus_out),
        .enable       (enable),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: packet active flag, cycles since acceptance, body length.
    bit m_active = 1'b0;
    int m_off    = 0;
    int m_len    = 0;

    int en_cnt   = 0;
    int br_cnt   = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic a, input logic sd, input logic sh,
                        input logic si);
        logic [1:0] e_bus;
        logic e_en, e_start, e_br, e_end, e_done, e_busy;
        @(negedge clk);
        rst = r; abort = a; send_data = sd; send_hshake = sh; s_in = si;
        #1;
        e_bus = LineJ; e_en = 0; e_start = 0; e_br = 0; e_end = 0; e_done = 0; e_busy = 0;
        if (m_active) begin
            e_en   = 1'b1;
            e_busy = 1'b1;
            if (m_off <= 8) begin
                e_bus = (m_off == 2 || m_off == 4 || m_off == 6) ? LineJ : LineK;
            end else if (m_off <= 8 + m_len) begin
                e_bus = si ? LineJ : LineK;
                e_br  = 1'b1;
                e_end = (m_off == 8 + m_len) && !a;
            end else if (m_off <= 10 + m_len) begin
                e_bus = LineX;
            end else begin
                e_done = !a;
            end
        end else begin
            e_start = (sd || sh) && !a;
        end
        check("bus_out", 8'(bus_out), 8'(e_bus));
        check("enable", 8'(enable), 8'(e_en));
        check("busy", 8'(busy), 8'(e_busy));
        check("start_tx_nrzi", 8'(start_tx_nrzi), 8'(e_start));
        check("bit_req", 8'(bit_req), 8'(e_br));
        check("end_tx_nrzi", 8'(end_tx_nrzi), 8'(e_end));
        check("tx_done", 8'(tx_done), 8'(e_done));
        if (enable === 1'b1) en_cnt++;
        if (bit_req === 1'b1) br_cnt++;
        if (tx_done === 1'b1) done_cnt++;
        if (r || a) begin
            m_active = 1'b0;
        end else if (m_active) begin
            m_off++;
            if (m_off == 12 + m_len) m_active = 1'b0;
        end else if (sd || sh) begin
            m_active = 1'b1;
            m_off    = 1;
            m_len    = sh ? HsBits : DataBits;
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(1)));
    endtask

    task automatic clear_counts();
        en_cnt = 0; br_cnt = 0; done_cnt = 0;
    endtask

    initial begin
        logic [7:0] pat;
        rst = 1'b1; abort = 1'b0; send_data = 1'b0; send_hshake = 1'b0; s_in = 1'b0;
        repeat (3) @(posedge clk);

        // Reset values.
        idle_steps(2);

        // Handshake with pattern 10110010.
        clear_counts();
        pat = 8'b10110010;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, pat[7-i]);
        idle_steps(5);
        check("hs_enable_cycles", 8'(en_cnt), 8'd19);
        check("hs_bit_reqs", 8'(br_cnt), 8'd8);
        check("hs_done_count", 8'(done_cnt), 8'd1);

        // Data packet, alternating s_in.
        clear_counts();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 102; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'(i % 2));
        check("data_enable_cycles", 8'(en_cnt), 8'd99);
        check("data_bit_reqs", 8'(br_cnt), 8'd88);
        check("data_done_count", 8'(done_cnt), 8'd1);

        // Simultaneous requests: handshake length wins.
        clear_counts();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle_steps(22);
        check("both_enable_cycles", 8'(en_cnt), 8'd19);

        // Abort at T+20 of a data packet, new handshake at T+21.
        clear_counts();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_steps(19);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("abort_no_done", 8'(done_cnt), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_steps(22);
        check("after_abort_done", 8'(done_cnt), 8'd1);

        // Abort in IDLE with a request present.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle_steps(2);

        // send_data during SEND of a handshake is ignored.
        clear_counts();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_steps(10);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_steps(15);
        check("midreq_done_count", 8'(done_cnt), 8'd1);
        check("midreq_enable_cycles", 8'(en_cnt), 8'd19);

        // Reset during SYNC, then a clean restart.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_steps(3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_steps(1);
        clear_counts();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_steps(22);
        check("post_reset_enable_cycles", 8'(en_cnt), 8'd19);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(299) == 0), 1'($urandom_range(199) == 0),
                 1'($urandom_range(9) == 0), 1'($urandom_range(9) == 0),
                 1'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
